metronome_seq: RTL and testbench

//  Parametrised step-sequencer metronome; successor to the single-pattern metronome.

---
 rtl/metronome_pkg.sv | 37 +++
 rtl/tone_gen.sv | 56 +++++
 rtl/metronome_seq.sv | 111 +++++++++++
 tb/tb_metronome_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
// Shared helpers, default-parameter derivations and the click FSM state type for the metronome.
package metronome_pkg;

  localparam int unsigned DEF_CLK_HZ    = 25_000_000;
  localparam int unsigned DEF_TONE_HZ   = 2500;
  localparam int unsigned DEF_ACCENT_HZ = 5000;
  localparam int unsigned DEF_BPM_W     = 8;

  // Bits needed to hold values 0..v-1; never returns less than 1.
  function automatic int unsigned clog2_safe(input longint unsigned v);
    int unsigned r = 1;
    for (int unsigned i = 1; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic longint unsigned limit_of(input longint unsigned clk_hz);
    return 64'd60 * clk_hz;
  endfunction

  function automatic int unsigned half_of(input longint unsigned clk_hz,
                                          input longint unsigned hz);
    return 32'(clk_hz / (64'd2 * hz));
  endfunction

  localparam longint unsigned LIMIT       = limit_of(64'(DEF_CLK_HZ));
  localparam int unsigned     ACC_W       = clog2_safe(LIMIT + (64'd1 << DEF_BPM_W));
  localparam int unsigned     HALF_TONE   = half_of(64'(DEF_CLK_HZ), 64'(DEF_TONE_HZ));
  localparam int unsigned     HALF_ACCENT = half_of(64'(DEF_CLK_HZ), 64'(DEF_ACCENT_HZ));

  typedef enum logic {
    IDLE,
    CLICK
  } click_state_t;

endpackage

// File: rtl/tone_gen.sv
// Gated square-wave generator with two selectable half-periods; restart forces a fresh high phase.
module tone_gen
  import metronome_pkg::*;
#(
  parameter int unsigned HALF_A = 5,
  parameter int unsigned HALF_B = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sel_b,
  input  logic restart,
  output logic sq
);

  localparam int unsigned HMAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned CW   = clog2_safe(64'(HMAX));

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic [CW-1:0] w_half_m1;
  logic          r_sq;
  logic          w_sq_d;

  assign w_half_m1 = sel_b ? CW'(HALF_B - 1) : CW'(HALF_A - 1);

  always_comb begin
    w_sq_d  = r_sq;
    w_cnt_d = r_cnt;
    if (restart) begin
      w_sq_d  = 1'b1;
      w_cnt_d = w_half_m1;
    end else if (!en) begin
      w_sq_d  = 1'b0;
      w_cnt_d = '0;
    end else if (r_cnt == '0) begin
      w_sq_d  = ~r_sq;
      w_cnt_d = w_half_m1;
    end else begin
      w_cnt_d = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sq  <= w_sq_d;
      r_cnt <= w_cnt_d;
    end
  end

  assign sq = r_sq;

endmodule

// File: rtl/metronome_seq.sv
// Step-sequencer metronome: exact phase-accumulator tempo, one-hot step LEDs and a gated click tone.
module metronome_seq
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned TONE_HZ   = 2500,
  parameter int unsigned ACCENT_HZ = 5000,
  parameter int unsigned CLICK_CYC = 2_500_000,
  parameter int unsigned STEPS     = 16,
  parameter int unsigned BPM_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [BPM_W-1:0]         bpm,
  input  logic [STEPS-1:0]         step_en,
  input  logic [STEPS-1:0]         accent_en,
  output logic                     bell,
  output logic [STEPS-1:0]         led,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_pulse
);

  localparam longint unsigned L_LIMIT       = limit_of(64'(CLK_HZ));
  localparam int unsigned     L_ACC_W       = clog2_safe(L_LIMIT + (64'd1 << BPM_W));
  localparam int unsigned     L_IDX_W       = $clog2(STEPS);
  localparam int unsigned     L_CNT_W       = clog2_safe(64'(CLICK_CYC));
  localparam int unsigned     L_HALF_TONE   = half_of(64'(CLK_HZ), 64'(TONE_HZ));
  localparam int unsigned     L_HALF_ACCENT = half_of(64'(CLK_HZ), 64'(ACCENT_HZ));
  localparam logic [L_ACC_W-1:0] L_LIMIT_C  = L_ACC_W'(L_LIMIT);

  logic [L_ACC_W-1:0] r_acc, w_sum, w_acc_d;
  logic               w_wrap;
  logic               r_started;
  logic [L_IDX_W-1:0] r_idx, w_next_idx;
  logic [STEPS-1:0]   r_led;
  logic               r_pulse;
  click_state_t       r_state, w_state_d;
  logic [L_CNT_W-1:0] r_cnt, w_cnt_d;
  logic               r_accent, w_sel;
  logic               w_start;
  logic               w_tone_en;

  // acc < LIMIT and bpm < 2**BPM_W, so the sum always fits in L_ACC_W bits.
  assign w_sum      = r_acc + L_ACC_W'(bpm);
  assign w_wrap     = run && (w_sum >= L_LIMIT_C);
  assign w_acc_d    = !run ? r_acc : (w_wrap ? (w_sum - L_LIMIT_C) : w_sum);
  // The first wrap lands on step 0 so the pattern opens with its first step.
  assign w_next_idx = (!r_started || (r_idx == L_IDX_W'(STEPS - 1))) ? '0
                                                                     : r_idx + L_IDX_W'(1);
  assign w_start    = w_wrap && step_en[w_next_idx];
  assign w_sel      = w_start ? accent_en[w_next_idx] : r_accent;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (w_start) begin
      w_state_d = CLICK;
      w_cnt_d   = L_CNT_W'(CLICK_CYC - 1);
    end else if (r_state == CLICK) begin
      if (!run || (r_cnt == '0)) begin
        w_state_d = IDLE;
      end else begin
        w_cnt_d = r_cnt - L_CNT_W'(1);
      end
    end
  end

  assign w_tone_en = (w_state_d == CLICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_started <= 1'b0;
      r_idx     <= '0;
      r_led     <= '0;
      r_pulse   <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_accent  <= 1'b0;
    end else begin
      r_acc    <= w_acc_d;
      r_pulse  <= w_wrap;
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_accent <= w_sel;
      if (w_wrap) begin
        r_started <= 1'b1;
        r_idx     <= w_next_idx;
        r_led     <= STEPS'(1) << w_next_idx;
      end
    end
  end

  tone_gen #(
    .HALF_A(L_HALF_TONE),
    .HALF_B(L_HALF_ACCENT)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (w_tone_en),
    .sel_b  (w_sel),
    .restart(w_start),
    .sq     (bell)
  );

  assign led        = r_led;
  assign step_idx   = r_idx;
  assign step_pulse = r_pulse;

endmodule

// File: tb/tb_metronome_seq.sv
// Directed and randomized checks of metronome_seq against a cycle-level behavioural model.
module tb_metronome_seq;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned TONE_HZ   = 100;
  localparam int unsigned ACCENT_HZ = 250;
  localparam int unsigned CLICK_CYC = 40;
  localparam int unsigned STEPS     = 4;
  localparam int unsigned BPM_W     = 8;
  localparam longint unsigned LIMIT = 60 * CLK_HZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] bpm = '0;
  logic [3:0] step_en = '0;
  logic [3:0] accent_en = '0;
  logic       bell;
  logic [3:0] led;
  logic [1:0] step_idx;
  logic       step_pulse;

  metronome_seq #(
    .CLK_HZ   (CLK_HZ),
    .TONE_HZ  (TONE_HZ),
    .ACCENT_HZ(ACCENT_HZ),
    .CLICK_CYC(CLICK_CYC),
    .STEPS    (STEPS),
    .BPM_W    (BPM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bpm       (bpm),
    .step_en   (step_en),
    .accent_en (accent_en),
    .bell      (bell),
    .led       (led),
    .step_idx  (step_idx),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  longint      cyc = 0;
  longint      pq[$];
  logic [3:0]  lq[$];

  // Behavioural model state
  longint unsigned m_acc;
  bit              m_started, m_pulse, m_active;
  int              m_idx, m_led, m_age, m_left, m_half;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_started = 0; m_pulse = 0; m_active = 0;
    m_idx = 0; m_led = 0; m_age = 0; m_left = 0; m_half = 1;
  endtask

  task automatic model_step();
    longint unsigned sum;
    bit wrap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    sum  = m_acc + 64'(bpm);
    wrap = run && (sum >= LIMIT);
    if (run) m_acc = wrap ? sum - LIMIT : sum;
    m_pulse = wrap;
    if (wrap) begin
      m_idx = m_started ? (m_idx + 1) % STEPS : 0;
      m_started = 1;
      m_led = 1 << m_idx;
    end
    if (wrap && step_en[m_idx]) begin
      m_active = 1; m_age = 0; m_left = CLICK_CYC - 1;
      m_half = accent_en[m_idx] ? CLK_HZ / (2 * ACCENT_HZ) : CLK_HZ / (2 * TONE_HZ);
    end else if (m_active) begin
      if (!run || m_left == 0) m_active = 0;
      else begin
        m_left--;
        m_age++;
      end
    end
  endtask

  function automatic int exp_bell();
    return (m_active && ((m_age / m_half) % 2 == 0)) ? 1 : 0;
  endfunction

  task automatic check_all();
    chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
    chk("led", 32'(led), m_led);
    chk("step_idx", 32'(step_idx), m_idx);
    chk("bell", 32'(bell), exp_bell());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (step_pulse === 1'b1) begin
      pq.push_back(cyc);
      lq.push_back(led);
    end
    check_all();
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step_pulse !== 1'b1 && n < budget);
    chk("pulse_within_budget", 32'(step_pulse), 1);
  endtask

  // Call on a step_pulse cycle: bell profile over the whole click and a little past it.
  task automatic bell_profile(input string tag, input int half, input bit enabled);
    for (int i = 0; i < 45; i++) begin
      if (i > 0) tick();
      chk(tag, 32'(bell), (enabled && i < CLICK_CYC && ((i / half) % 2 == 0)) ? 1 : 0);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_bell", 32'(bell), 0);
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_idx", 32'(step_idx), 0);
    chk("async_rst_pulse", 32'(step_pulse), 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int n, k;
    int halves[4];
    bit ens[4];
    logic [3:0] held_led;
    int held_idx, np;

    model_reset();
    // Reset state
    #1;
    chk("reset_bell", 32'(bell), 0);
    chk("reset_led", 32'(led), 0);
    chk("reset_idx", 32'(step_idx), 0);
    chk("reset_pulse", 32'(step_pulse), 0);

    // 1: steady 60 bpm, all steps, no accent
    run = 1'b1; bpm = 8'd60; step_en = 4'hF; accent_en = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pq.delete(); lq.delete();
    for (int s = 0; s < 5; s++) begin
      wait_pulse(1100, n);
      bell_profile("t1_bell", 5, 1'b1);
    end
    chk("t1_pulse_count", 32'(pq.size()), 5);
    for (int i = 0; i < pq.size(); i++) begin
      chk("t1_led_seq", 32'(lq[i]), 1 << (i % 4));
      if (i == 0) chk("t1_first_pulse", 32'(pq[0]), 1000);
      else chk("t1_spacing", 32'(pq[i] - pq[i-1]), 1000);
    end

    // 2: accent on step 0 only; steps 1,2,3,0 follow
    accent_en = 4'b0001;
    halves = '{5, 5, 5, 2};
    for (int s = 0; s < 4; s++) begin
      wait_pulse(1100, n);
      bell_profile("t2_bell", halves[s], 1'b1);
    end

    // 3: only steps 0 and 2 click; steps 1,2,3,0 follow
    accent_en = 4'b0000; step_en = 4'b0101;
    ens = '{1'b0, 1'b1, 1'b0, 1'b1};
    lq.delete();
    for (int s = 0; s < 4; s++) begin
      wait_pulse(1100, n);
      bell_profile("t3_bell", 5, ens[s]);
    end
    chk("t3_led_walk_count", 32'(lq.size()), 4);
    for (int i = 0; i < lq.size(); i++) chk("t3_led_walk", 32'(lq[i]), 1 << ((i + 1) % 4));

    // Randomized: tempo, patterns changed mid-step, short run dropouts
    for (int s = 0; s < 6; s++) begin
      bpm = 8'($urandom_range(200, 255));
      step_en = 4'($urandom); accent_en = 4'($urandom);
      wait_pulse(400, n);
      repeat (3) tick();
      step_en = 4'($urandom); accent_en = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        run = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
        run = 1'b1;
      end
    end

    // 5: run dropped mid-click, then resumed
    bpm = 8'd60; step_en = 4'hF; accent_en = 4'h0;
    wait_pulse(1100, n);
    repeat (10) tick();
    run = 1'b0;
    tick();
    chk("t5_bell_off", 32'(bell), 0);
    held_led = 4'(m_led); held_idx = m_idx;
    repeat (50) tick();
    chk("t5_led_hold", 32'(led), 32'(held_led));
    chk("t5_idx_hold", 32'(step_idx), held_idx);
    chk("t5_bell_silent", 32'(bell), 0);
    k = int'((LIMIT - m_acc + 64'(bpm) - 1) / 64'(bpm));
    run = 1'b1;
    wait_pulse(1100, n);
    chk("t5_resume_distance", n, k);

    // 6: async reset mid-click, then bpm=0 never steps
    wait_pulse(1100, n);
    repeat (3) tick();
    async_reset();
    bpm = 8'd0; run = 1'b1;
    np = pq.size();
    repeat (10000) tick();
    chk("t6_no_pulse_bpm0", 32'(pq.size() - np), 0);

    // 4: bpm=7 from a zero accumulator; 7 steps span exactly 60000 cycles
    bpm = 8'd7;
    cyc = 0;
    pq.delete();
    for (int s = 0; s < 7; s++) wait_pulse(9000, n);
    chk("t4_pulse_count", 32'(pq.size()), 7);
    for (int i = 0; i < pq.size(); i++) begin
      if (i == 0) chk("t4_first_pulse", 32'(pq[0]), 8572);
      else chk("t4_spacing", ((pq[i] - pq[i-1]) == 8571 || (pq[i] - pq[i-1]) == 8572) ? 1 : 0, 1);
    end
    if (pq.size() == 7) chk("t4_total", 32'(pq[6]), 60000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
